// File: rtl/conv_layer_scheduler.sv
// Layer sequencer for the accelerator input path: weight load, image load,
// then one start/done handshake per (input channel, output channel) pass.
module conv_layer_scheduler #(
  parameter int NUM_LAYERS = 3,
  parameter int L0_IC      = 1,
  parameter int L0_OC      = 64,
  parameter int L1_IC      = 64,
  parameter int L1_OC      = 64,
  parameter int L2_IC      = 64,
  parameter int L2_OC      = 1,
  parameter int L3_IC      = 1,
  parameter int L3_OC      = 1,
  parameter int CH_W       = 6
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_start,
  input  logic            i_wload_done,
  input  logic            i_iload_done,
  input  logic            i_conv_done,
  input  logic            i_irq_clr,
  output logic            o_state,
  output logic [1:0]      o_layer,
  output logic            o_pass_start,
  output logic            o_last,
  output logic [CH_W-1:0] o_ic_idx,
  output logic [CH_W-1:0] o_oc_idx,
  output logic            o_busy,
  output logic            o_done,
  output logic            o_irq,
  output logic            o_err
);

  typedef enum logic [2:0] {
    S_IDLE, S_W_LOAD, S_I_LOAD, S_ISSUE, S_WAIT, S_LAYER_END, S_FINISH
  } state_t;

  localparam logic [1:0] LAST_LAYER = 2'(NUM_LAYERS - 1);

  // Terminal channel indices per layer; channel counts of 0 are illegal.
  function automatic logic [CH_W-1:0] ic_max(input logic [1:0] l);
    case (l)
      2'd0:    ic_max = CH_W'(L0_IC - 1);
      2'd1:    ic_max = CH_W'(L1_IC - 1);
      2'd2:    ic_max = CH_W'(L2_IC - 1);
      default: ic_max = CH_W'(L3_IC - 1);
    endcase
  endfunction

  function automatic logic [CH_W-1:0] oc_max(input logic [1:0] l);
    case (l)
      2'd0:    oc_max = CH_W'(L0_OC - 1);
      2'd1:    oc_max = CH_W'(L1_OC - 1);
      2'd2:    oc_max = CH_W'(L2_OC - 1);
      default: oc_max = CH_W'(L3_OC - 1);
    endcase
  endfunction

  state_t          state, nxt_state;
  logic [1:0]      nxt_layer;
  logic [CH_W-1:0] nxt_ic, nxt_oc;
  logic            nxt_sel, nxt_last;

  always_comb begin
    nxt_state = state;
    nxt_layer = o_layer;
    nxt_ic    = o_ic_idx;
    nxt_oc    = o_oc_idx;
    nxt_sel   = o_state;
    case (state)
      S_IDLE:   if (i_start) nxt_state = S_W_LOAD;
      S_W_LOAD: if (i_wload_done) nxt_state = S_I_LOAD;
      S_I_LOAD: if (i_iload_done) begin
        nxt_state = S_ISSUE;
        nxt_layer = '0;
        nxt_ic    = '0;
        nxt_oc    = '0;
      end
      S_ISSUE:  nxt_state = S_WAIT;
      S_WAIT:   if (i_conv_done) begin
        if (o_ic_idx == ic_max(o_layer) && o_oc_idx == oc_max(o_layer)) begin
          nxt_state = S_LAYER_END;
        end else if (o_ic_idx == ic_max(o_layer)) begin
          nxt_state = S_ISSUE;
          nxt_ic    = '0;
          nxt_oc    = o_oc_idx + CH_W'(1);
        end else begin
          nxt_state = S_ISSUE;
          nxt_ic    = o_ic_idx + CH_W'(1);
        end
      end
      S_LAYER_END: begin
        if (o_layer == LAST_LAYER) begin
          nxt_state = S_FINISH;
        end else begin
          nxt_state = S_ISSUE;
          nxt_layer = o_layer + 2'd1;
          nxt_ic    = '0;
          nxt_oc    = '0;
        end
      end
      S_FINISH: nxt_state = S_IDLE;
      default:  nxt_state = S_IDLE;
    endcase
    // Buffer select follows the load state and holds its value elsewhere.
    if (nxt_state == S_W_LOAD) nxt_sel = 1'b0;
    if (nxt_state == S_I_LOAD) nxt_sel = 1'b1;
    nxt_last = (nxt_state == S_ISSUE || nxt_state == S_WAIT) &&
               nxt_layer == LAST_LAYER &&
               nxt_ic == ic_max(nxt_layer) && nxt_oc == oc_max(nxt_layer);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state        <= S_IDLE;
      o_state      <= 1'b0;
      o_layer      <= '0;
      o_ic_idx     <= '0;
      o_oc_idx     <= '0;
      o_pass_start <= 1'b0;
      o_last       <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_irq        <= 1'b0;
      o_err        <= 1'b0;
    end else begin
      state        <= nxt_state;
      o_state      <= nxt_sel;
      o_layer      <= nxt_layer;
      o_ic_idx     <= nxt_ic;
      o_oc_idx     <= nxt_oc;
      o_pass_start <= (state == S_ISSUE);
      o_last       <= nxt_last;
      o_busy       <= (nxt_state != S_IDLE);
      o_done       <= (state == S_FINISH);
      // Completion set takes priority over a coincident clear.
      if (state == S_FINISH) o_irq <= 1'b1;
      else if (i_irq_clr)    o_irq <= 1'b0;
      if (i_conv_done && state != S_WAIT) o_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_conv_layer_scheduler.sv
// Directed bench for conv_layer_scheduler: full 3-layer run, load ordering,
// index wrap, spurious conv_done, async reset and irq handling.
module tb_conv_layer_scheduler;
  localparam int CH_W = 6;

  logic clk = 1'b0;
  logic rstn = 1'b1;
  logic i_start = 1'b0, i_wload_done = 1'b0, i_iload_done = 1'b0;
  logic i_conv_done = 1'b0, i_irq_clr = 1'b0;
  logic o_state, o_pass_start, o_last, o_busy, o_done, o_irq, o_err;
  logic [1:0] o_layer;
  logic [CH_W-1:0] o_ic_idx, o_oc_idx;

  conv_layer_scheduler dut (
    .clk(clk), .rstn(rstn), .i_start(i_start), .i_wload_done(i_wload_done),
    .i_iload_done(i_iload_done), .i_conv_done(i_conv_done), .i_irq_clr(i_irq_clr),
    .o_state(o_state), .o_layer(o_layer), .o_pass_start(o_pass_start),
    .o_last(o_last), .o_ic_idx(o_ic_idx), .o_oc_idx(o_oc_idx), .o_busy(o_busy),
    .o_done(o_done), .o_irq(o_irq), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0, passes = 0;
  int ics[3] = '{1, 64, 64};
  int ocs[3] = '{64, 64, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] all_out();
    return {11'd0, o_state, o_layer, o_pass_start, o_last, o_ic_idx, o_oc_idx,
            o_busy, o_done, o_irq, o_err};
  endfunction

  // Wait for a start pulse, check indices/last, return conv_done d cycles later.
  task automatic do_pass(input int d, input int el, input int eic, input int eoc,
                         input logic elast);
    int n = 0;
    logic [31:0] eidx;
    eidx = {18'd0, 2'(el), 6'(eic), 6'(eoc)};
    while (!o_pass_start && n < 20) begin tick; n++; end
    if (!o_pass_start) begin
      chk("pass_timeout", {31'd0, o_pass_start}, 32'd1);
      return;
    end
    passes++;
    chk("pass_idx", {18'd0, o_layer, o_ic_idx, o_oc_idx}, eidx);
    chk("pass_last", {31'd0, o_last}, {31'd0, elast});
    repeat (d - 1) tick;
    chk("idx_stable", {18'd0, o_layer, o_ic_idx, o_oc_idx}, eidx);
    i_conv_done = 1'b1;
    tick;
    i_conv_done = 1'b0;
  endtask

  initial begin
    // Reset state.
    #2 rstn = 1'b0;
    #20 rstn = 1'b1;
    tick;
    chk("reset_outs", all_out(), 32'd0);

    // Spurious conv_done in IDLE sets err only.
    i_conv_done = 1'b1;
    tick;
    i_conv_done = 1'b0;
    chk("idle_spur_err", {31'd0, o_err}, 32'd1);
    chk("idle_spur_busy", {31'd0, o_busy}, 32'd0);
    rstn = 1'b0;
    #2;
    chk("err_reset", {31'd0, o_err}, 32'd0);
    rstn = 1'b1;
    tick;

    // Load ordering: early iload_done ignored.
    i_start = 1'b1; tick; i_start = 1'b0;
    chk("wload_busy", {31'd0, o_busy}, 32'd1);
    i_iload_done = 1'b1; tick; i_iload_done = 1'b0;
    tick;
    chk("early_iload_sel", {31'd0, o_state}, 32'd0);
    chk("early_iload_nostart", {31'd0, o_pass_start}, 32'd0);
    i_wload_done = 1'b1; tick; i_wload_done = 1'b0;
    chk("iload_sel", {31'd0, o_state}, 32'd1);
    i_iload_done = 1'b1; tick; i_iload_done = 1'b0;
    // This cycle is ISSUE: a conv_done here is spurious.
    i_conv_done = 1'b1;
    chk("first_start_early", {31'd0, o_pass_start}, 32'd0);
    tick;
    i_conv_done = 1'b0;
    chk("first_start_2cyc", {31'd0, o_pass_start}, 32'd1);
    chk("issue_spur_err", {31'd0, o_err}, 32'd1);

    // Nominal run: 64 + 4096 + 64 passes.
    for (int l = 0; l < 3; l++)
      for (int oc = 0; oc < ocs[l]; oc++)
        for (int ic = 0; ic < ics[l]; ic++) begin
          if (passes == 2000) begin
            i_start = 1'b1; tick; i_start = 1'b0;
            chk("start_while_busy", {31'd0, o_busy}, 32'd1);
          end
          if (l == 1 && oc == 6 && ic == 0)
            chk("wrap_idx", {26'd0, o_ic_idx}, 32'd0);
          do_pass(5, l, ic, oc, passes == 4223);
        end
    chk("total_starts", passes, 32'd4224);

    // conv_done was sampled; now LAYER_END. Next cycle is FINISH.
    tick;
    i_irq_clr = 1'b1;
    tick;
    i_irq_clr = 1'b0;
    chk("done_pulse", {31'd0, o_done}, 32'd1);
    chk("irq_set_wins", {31'd0, o_irq}, 32'd1);
    chk("idle_busy", {31'd0, o_busy}, 32'd0);
    tick;
    chk("done_once", {31'd0, o_done}, 32'd0);
    chk("irq_sticky", {31'd0, o_irq}, 32'd1);
    i_irq_clr = 1'b1; tick; i_irq_clr = 1'b0;
    chk("irq_clr", {31'd0, o_irq}, 32'd0);

    // Restart, run into layer 1 oc=10, then async reset.
    i_start = 1'b1; tick; i_start = 1'b0;
    chk("restart_sel", {31'd0, o_state}, 32'd0);
    i_wload_done = 1'b1; tick; i_wload_done = 1'b0;
    i_iload_done = 1'b1; tick; i_iload_done = 1'b0;
    passes = 0;
    for (int ic = 0; ic < 64 * 0 + 1; ic++)
      for (int oc = 0; oc < 64; oc++) do_pass(1, 0, 0, oc, 1'b0);
    for (int oc = 0; oc < 10; oc++)
      for (int ic = 0; ic < 64; ic++) do_pass(1, 1, ic, oc, 1'b0);
    for (int ic = 0; ic < 5; ic++) do_pass(1, 1, ic, 10, 1'b0);
    tick;
    chk("mid_l1_idx", {18'd0, o_layer, o_ic_idx, o_oc_idx}, {18'd0, 2'd1, 6'd5, 6'd10});
    chk("mid_l1_busy", {31'd0, o_busy}, 32'd1);
    #3 rstn = 1'b0;
    #1;
    chk("async_reset_outs", all_out(), 32'd0);
    #10 rstn = 1'b1;
    tick;
    chk("post_reset_idle", {31'd0, o_busy}, 32'd0);
    i_start = 1'b1; tick; i_start = 1'b0;
    tick;
    chk("post_reset_wload", {30'd0, o_busy, o_state}, 32'd2);
    chk("post_reset_nostart", {31'd0, o_pass_start}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout obs=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/conv_layer_scheduler.md
Name: conv_layer_scheduler

Overview:
- Top-level sequencer for the editing accelerator input path.
- Steps the input buffer through its load phases: weights, then images.
- Then runs every layer pass by pass. One pass is one (input channel, output channel) convolution. The scheduler issues a start pulse per pass and waits for conv_done.
- Drives the buffer's state, layer and last controls, and raises a done interrupt to the PS side.

Parameters:
- NUM_LAYERS, 3, number of layers sequenced (max 4).
- L0_IC, 1, input channels of layer 0.
- L0_OC, 64, output channels of layer 0.
- L1_IC, 64, input channels of layer 1.
- L1_OC, 64, output channels of layer 1.
- L2_IC, 64, input channels of layer 2.
- L2_OC, 1, output channels of layer 2.
- CH_W, 6, width of the channel index counters.

Ports:
- clk  in  1  clock
- rstn  in  1  asynchronous active-low reset
- i_start  in  1  one-cycle run request from the control register
- i_wload_done  in  1  pulse: weight stream tlast accepted
- i_iload_done  in  1  pulse: image stream tlast accepted
- i_conv_done  in  1  pulse: current pass finished
- i_irq_clr  in  1  pulse: clear o_irq
- o_state  out  1  buffer load select: 0 = weights, 1 = images
- o_layer  out  2  current layer index
- o_pass_start  out  1  one-cycle pulse: begin a pass
- o_last  out  1  high during the final pass of the final layer
- o_ic_idx  out  CH_W  current input channel
- o_oc_idx  out  CH_W  current output channel
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse: all layers complete
- o_irq  out  1  sticky completion interrupt
- o_err  out  1  sticky protocol error

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters 0. Reset is asynchronous and aborts any operation in progress; after release the block is in IDLE.
- FSM states and transitions:
  - IDLE: on i_start go to W_LOAD.
  - W_LOAD: o_state=0. On i_wload_done go to I_LOAD.
  - I_LOAD: o_state=1. On i_iload_done go to ISSUE, with layer=0, ic=0, oc=0.
  - ISSUE: o_pass_start=1 for exactly one cycle, then go to WAIT.
  - WAIT: on i_conv_done:
    - if ic==IC(layer)-1 and oc==OC(layer)-1, go to LAYER_END;
    - else if ic==IC-1, set ic=0, oc=oc+1 and go to ISSUE;
    - else set ic=ic+1 and go to ISSUE.
  - LAYER_END: if layer==NUM_LAYERS-1, go to FINISH. Otherwise layer+1, ic=oc=0, go to ISSUE.
  - FINISH: o_done=1 for one cycle, set o_irq, go to IDLE.
- o_state holds its last value outside the load states (1 after I_LOAD completes).
- All outputs are registered. o_pass_start is asserted on the first clock edge after ISSUE is entered.
- Minimum spacing between start pulses is 2 cycles, including the conv_done cycle.
- o_last = (layer==NUM_LAYERS-1) and (ic==IC-1) and (oc==OC-1), qualified by ISSUE or WAIT.
- o_ic_idx, o_oc_idx and o_layer are stable from o_pass_start until the matching i_conv_done.
- Passes per layer = IC*OC. Counters compare against the parameter minus 1. Parameters of 0 are illegal.
- i_start while o_busy: ignored.
- i_wload_done or i_iload_done outside its own load state: ignored.
- i_conv_done outside WAIT: ignored, and sets o_err.
- o_err and o_irq are cleared only by reset; o_irq is also cleared by i_irq_clr. If i_irq_clr and the set condition occur in the same cycle, set wins.

Test Plan:
- Nominal run, IC/OC = 1/64, 64/64, 64/1, conv_done returned 5 cycles after each start -> 64+4096+64 = 4224 start pulses. o_layer steps 0→1→2. o_last is high for pass 4224 only. o_done fires once, o_irq=1.
- Load ordering: i_iload_done pulsed before i_wload_done -> ignored, FSM stays in W_LOAD with o_state=0. Then wload, then iload -> first o_pass_start exactly 2 cycles after iload_done.
- Index wrap in layer 1: ic=63, oc=5, then conv_done -> ic=0, oc=6 on the next start.
- Spurious i_conv_done in ISSUE or in IDLE -> o_err=1, no index change, sequencing continues normally.
- Async reset asserted mid-layer 1 (oc=10) -> all outputs 0 immediately, without waiting for clk. After release, i_start restarts at W_LOAD.
- IRQ handling: i_irq_clr in the same cycle as FINISH -> o_irq=1. A later i_irq_clr -> o_irq=0. i_start while busy -> no effect.
